// File: rtl/dvp_rgb565_transmitter_if.sv
// dvp_rgb565_transmitter_if: upstream pixel handshake plus DVP byte bus
interface dvp_rgb565_transmitter_if;
  logic [15:0] pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic        cmos_vsync;
  logic        cmos_href;
  logic [7:0]  cmos_data;
  modport master (input pix_data, pix_valid, output pix_ready, cmos_vsync, cmos_href, cmos_data);
  modport slave  (output pix_data, pix_valid, input pix_ready, cmos_vsync, cmos_href, cmos_data);
endinterface

// File: rtl/dvp_rgb565_transmitter.sv
// dvp_rgb565_transmitter: frames RGB565 pixels (upstream or colour bars) onto an 8-bit DVP bus
module dvp_rgb565_transmitter #(
  parameter int H_ACTIVE = 640,
  parameter int H_BLANK  = 144,
  parameter int V_SYNC   = 3,
  parameter int V_BACK   = 17,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10
) (
  input  logic cmos_pclk,
  input  logic sys_rstn,
  input  logic enable,
  input  logic test_pattern,
  output logic frame_start,
  output logic pix_underflow,
  dvp_rgb565_transmitter_if.master bus
);
  typedef enum logic [2:0] {IDLE, VSYNC, VBACK, ACTIVE, VFRONT} state_t;
  localparam int L  = 2*H_ACTIVE + H_BLANK;
  localparam int HW = $clog2(L);
  localparam int W  = H_ACTIVE/8;
  localparam int WW = $clog2(W+1);
  localparam logic [HW-1:0] H_LAST = HW'(L-1);
  localparam logic [HW-1:0] H_ACT  = HW'(2*H_ACTIVE);
  localparam logic [WW-1:0] W_LAST = WW'(W-1);
  localparam logic [7:0][15:0] BARS = {16'h0000, 16'h001F, 16'hF800, 16'hF81F,
                                       16'h07E0, 16'h07FF, 16'hFFE0, 16'hFFFF};
  state_t state_q, state_d;
  logic [HW-1:0] h_q, h_d;
  logic [15:0] line_q, line_d, line_last, px;
  logic [7:0] data_q, data_d, lo_q, lo_d;
  logic [WW-1:0] wid_q, wid_d;
  logic [2:0] bar_q, bar_d;
  logic mode_q, mode_d, vsync_q, vsync_d, href_q, href_d, fs_q, fs_d, uf_q, uf_d;
  logic eol, eos, act, req, rdy;
  always_ff @(posedge cmos_pclk or negedge sys_rstn)
    if (!sys_rstn) begin
      state_q <= IDLE;
      h_q     <= '0;
      line_q  <= '0;
      mode_q  <= 1'b0;
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      fs_q    <= 1'b0;
      uf_q    <= 1'b0;
      data_q  <= '0;
      lo_q    <= '0;
      wid_q   <= '0;
      bar_q   <= '0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      line_q  <= line_d;
      mode_q  <= mode_d;
      vsync_q <= vsync_d;
      href_q  <= href_d;
      fs_q    <= fs_d;
      uf_q    <= uf_d;
      data_q  <= data_d;
      lo_q    <= lo_d;
      wid_q   <= wid_d;
      bar_q   <= bar_d;
    end
  assign line_last = state_q == VSYNC ? 16'(V_SYNC-1) :
                     state_q == VBACK ? 16'(V_BACK-1) :
                     state_q == ACTIVE ? 16'(V_ACTIVE-1) : 16'(V_FRONT-1);
  assign eol = h_q == H_LAST;
  assign eos = eol && line_q == line_last;
  always_comb begin
    state_d = state_q;
    h_d     = '0;
    line_d  = '0;
    if (state_q == IDLE)
      state_d = enable ? VSYNC : IDLE;
    else begin
      h_d    = eol ? '0 : h_q + 1'b1;
      line_d = eos ? '0 : eol ? line_q + 16'd1 : line_q;
      if (eos)
        state_d = state_q == VSYNC ? VBACK :
                  state_q == VBACK ? ACTIVE :
                  state_q == ACTIVE ? VFRONT : enable ? VSYNC : IDLE;
    end
    mode_d = (state_d == VSYNC && state_q != VSYNC) ? test_pattern : mode_q;
  end
  // Even byte slots load a whole pixel; the odd slot replays its stored low byte.
  always_comb begin
    act     = state_q == ACTIVE && h_q < H_ACT;
    req     = act && !h_q[0];
    rdy     = req && !mode_q;
    px      = mode_q ? BARS[bar_q] : bus.pix_valid ? bus.pix_data : 16'h0000;
    vsync_d = state_q == VSYNC;
    href_d  = act;
    data_d  = !act ? 8'h00 : h_q[0] ? lo_q : px[15:8];
    lo_d    = req ? px[7:0] : lo_q;
    fs_d    = state_q == VSYNC && h_q == '0 && line_q == '0;
    uf_d    = fs_d ? 1'b0 : (rdy && !bus.pix_valid) ? 1'b1 : uf_q;
    wid_d   = !act ? '0 : !req ? wid_q : wid_q == W_LAST ? '0 : wid_q + 1'b1;
    bar_d   = !act ? '0 : (req && wid_q == W_LAST) ? bar_q + 3'd1 : bar_q;
  end
  assign bus.pix_ready  = rdy;
  assign bus.cmos_vsync = vsync_q;
  assign bus.cmos_href  = href_q;
  assign bus.cmos_data  = data_q;
  assign frame_start    = fs_q;
  assign pix_underflow  = uf_q;
endmodule

// File: tb/tb_dvp_rgb565_transmitter.sv
// tb_dvp_rgb565_transmitter: random and directed frames checked against a frame-position model
module tb_dvp_rgb565_transmitter;
  localparam int HA = 8, HB = 4, VS = 1, VB = 1, VA = 2, VF = 1;
  localparam int L = 2*HA + HB;
  localparam int F = (VS + VB + VA + VF) * L;
  localparam int A0 = (VS + VB) * L;
  localparam int A1 = (VS + VB + VA) * L;
  logic clk = 1'b0, rstn = 1'b0, enable = 1'b0, test_pattern = 1'b0;
  logic frame_start, pix_underflow;
  dvp_rgb565_transmitter_if bus();
  dvp_rgb565_transmitter #(.H_ACTIVE(HA), .H_BLANK(HB), .V_SYNC(VS), .V_BACK(VB),
    .V_ACTIVE(VA), .V_FRONT(VF)) dut (.cmos_pclk(clk), .sys_rstn(rstn), .enable(enable),
    .test_pattern(test_pattern), .frame_start(frame_start), .pix_underflow(pix_underflow), .bus(bus));
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0;
  task automatic chk(input string nm, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask
  logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
  logic [7:0] tpb [16] = '{8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'h07, 8'hFF, 8'h07, 8'hE0,
                           8'hF8, 8'h1F, 8'hF8, 8'h00, 8'h00, 8'h1F, 8'h00, 8'h00};
  // Model: pos is the position of the frame clock (-1 when idle); outputs follow one clock later.
  int pos = -1, mcur, mh;
  bit mmode = 1'b0, e_vs = 1'b0, e_href = 1'b0, e_fs = 1'b0, e_uf = 1'b0;
  logic [7:0] e_data = 8'h00;
  logic [15:0] mpx;
  logic [7:0] bq [$];
  always @(posedge clk or negedge rstn)
    if (!rstn) begin
      pos = -1; mmode = 1'b0; bq.delete();
      e_vs = 1'b0; e_href = 1'b0; e_fs = 1'b0; e_uf = 1'b0; e_data = 8'h00;
    end else begin
      mcur = pos;
      mh = mcur < 0 ? 0 : mcur % L;
      e_vs = mcur >= 0 && mcur < VS*L;
      e_fs = mcur == 0;
      e_href = mcur >= A0 && mcur < A1 && mh < 2*HA;
      if (e_href && mh % 2 == 0) begin
        mpx = mmode ? bars[(mh/2)/(HA/8)] : bus.pix_valid ? bus.pix_data : 16'h0000;
        bq.push_back(mpx[15:8]);
        bq.push_back(mpx[7:0]);
      end
      e_data = e_href ? bq.pop_front() : 8'h00;
      if (e_fs) e_uf = 1'b0;
      else if (e_href && mh % 2 == 0 && !mmode && !bus.pix_valid) e_uf = 1'b1;
      if (mcur < 0 || mcur == F-1) begin
        pos = enable ? 0 : -1;
        if (enable) mmode = test_pattern;
      end else pos++;
    end
  always @(negedge clk) begin : cmp
    int ch;
    ch = pos < 0 ? 0 : pos % L;
    chk("vsync", bus.cmos_vsync, e_vs);
    chk("href", bus.cmos_href, e_href);
    chk("data", bus.cmos_data, e_data);
    chk("frame_start", frame_start, e_fs);
    chk("underflow", pix_underflow, e_uf);
    chk("pix_ready", bus.pix_ready, pos >= A0 && pos < A1 && ch < 2*HA && ch % 2 == 0 && !mmode);
  end
  bit src_rand = 1'b0, drop_arm = 1'b0, took = 1'b0;
  int rq = 0;
  always @(negedge clk)
    if (!rstn && !src_rand) begin
      bus.pix_data = 16'h1234; bus.pix_valid = 1'b0; took = 1'b0;
    end else begin
      if (src_rand) begin
        bus.pix_data = 16'($urandom);
        bus.pix_valid = $urandom_range(0, 7) != 0;
      end else begin
        if (took) bus.pix_data = bus.pix_data + 16'h4444;
        bus.pix_valid = 1'b1;
        if (drop_arm && bus.pix_ready) begin
          if (rq == 2) bus.pix_valid = 1'b0;
          rq++;
        end
      end
      took = bus.pix_ready && bus.pix_valid;
    end
  logic [7:0] cap [64];
  int ncap, s_vs, s_fh, s_hr, s_rq, s_wait;
  bit s_uf0, s_uf_end;
  task automatic run_frame(input int tp, input int en);
    s_wait = 0;
    while (!frame_start && s_wait < 300) begin @(negedge clk); s_wait++; end
    if (s_wait >= 300) begin chk("frame_timeout", 0, 1); return; end
    s_vs = 0; s_fh = -1; s_hr = 0; s_rq = 0; ncap = 0; s_uf0 = pix_underflow;
    for (int i = 0; i < F; i++) begin
      if (i > 0) @(negedge clk);
      if (bus.cmos_vsync) s_vs++;
      if (bus.cmos_href) begin
        if (s_hr == 0) s_fh = i;
        s_hr++;
        if (ncap < 64) cap[ncap] = bus.cmos_data;
        ncap++;
      end
      if (bus.pix_ready) s_rq++;
      if (i == 50 && tp >= 0) test_pattern = tp[0];
      if (i == 50 && en >= 0) enable = en[0];
    end
    s_uf_end = pix_underflow;
  endtask
  initial begin : main
    int quiet;
    repeat (3) @(negedge clk);
    chk("rst_vsync", bus.cmos_vsync, 0);
    chk("rst_href", bus.cmos_href, 0);
    chk("rst_data", bus.cmos_data, 0);
    chk("rst_fs", frame_start, 0);
    chk("rst_uf", pix_underflow, 0);
    chk("rst_ready", bus.pix_ready, 0);
    rstn = 1'b1;
    repeat (5) @(negedge clk);
    enable = 1'b1;
    run_frame(-1, -1);
    chk("first_fs_latency", s_wait, 2);
    chk("vsync_cycles", s_vs, VS*L);
    chk("first_href_offset", s_fh, A0);
    chk("href_cycles", s_hr, 2*HA*VA);
    chk("requests", s_rq, HA*VA);
    chk("byte0", cap[0], 8'h12);
    chk("byte1", cap[1], 8'h34);
    chk("byte2", cap[2], 8'h56);
    chk("byte3", cap[3], 8'h78);
    chk("uf_clean", s_uf_end, 0);
    drop_arm = 1'b1;
    run_frame(1, -1);
    chk("drop_hi", cap[4], 8'h00);
    chk("drop_lo", cap[5], 8'h00);
    chk("uf_start", s_uf0, 0);
    chk("uf_sticky", s_uf_end, 1);
    drop_arm = 1'b0;
    run_frame(0, -1);
    chk("uf_cleared", s_uf0, 0);
    chk("tp_requests", s_rq, 0);
    for (int i = 0; i < 32; i++) chk($sformatf("tp_byte%0d", i), cap[i], tpb[i % 16]);
    src_rand = 1'b1;
    for (int f = 0; f < 5; f++) begin
      run_frame(int'($urandom_range(0, 1)), -1);
      chk("rand_vsync", s_vs, VS*L);
      chk("rand_href", s_hr, 2*HA*VA);
    end
    run_frame(-1, 0);
    chk("stop_vsync", s_vs, VS*L);
    chk("stop_href", s_hr, 2*HA*VA);
    quiet = 0;
    repeat (40) begin
      @(negedge clk);
      quiet += int'(bus.cmos_vsync) + int'(bus.cmos_href) + int'(frame_start) + int'(bus.pix_ready);
    end
    chk("idle_quiet", quiet, 0);
    enable = 1'b1;
    run_frame(-1, -1);
    chk("reenable_latency", s_wait, 2);
    s_wait = 0;
    while (!frame_start && s_wait < 300) begin @(negedge clk); s_wait++; end
    repeat (45) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("arst_vsync", bus.cmos_vsync, 0);
    chk("arst_href", bus.cmos_href, 0);
    chk("arst_data", bus.cmos_data, 0);
    chk("arst_ready", bus.pix_ready, 0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    run_frame(-1, -1);
    chk("post_rst_vsync", s_vs, VS*L);
    chk("post_rst_href", s_hr, 2*HA*VA);
    chk("post_rst_first_href", s_fh, A0);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dvp_rgb565_transmitter.md
Name: dvp_rgb565_transmitter

Overview:
- Drives an 8-bit DVP camera-style interface (vsync/href/data) carrying RGB565 pixels as two bytes per pixel, MSB byte first.
- Serves as the sensor side of our CMOS capture path: a loopback source for capture-chain bring-up and a sensor model for FPGA-to-FPGA video links.
- Pixels come from an upstream stream with a ready/valid handshake, or from an internal 8-bar colour pattern.
- Frame timing is fully parameterised.

Parameters:
H_ACTIVE, 640, active pixels per line; must be a multiple of 8
H_BLANK, 144, href-low clocks per line
V_SYNC, 3, lines with vsync high at frame start
V_BACK, 17, blank lines after vsync, before the first active line
V_ACTIVE, 480, active lines per frame
V_FRONT, 10, blank lines after the last active line

Ports:
cmos_pclk  input  1  pixel byte clock; all logic on rising edge
sys_rstn  input  1  asynchronous active-low reset
enable  input  1  1 = generate frames continuously; 0 = stop at the next frame boundary
test_pattern  input  1  1 = colour bars, 0 = upstream pixels; sampled only at frame start
pix_data  input  16  upstream RGB565 pixel {R[4:0],G[5:0],B[4:0]}
pix_valid  input  1  pix_data is valid
pix_ready  output  1  transmitter takes a pixel this cycle if pix_valid is high
cmos_vsync  output  1  frame sync, high during V_SYNC lines
cmos_href  output  1  high while active bytes are on cmos_data
cmos_data  output  8  DVP byte
frame_start  output  1  one-cycle pulse coinciding with the first vsync-high cycle
pix_underflow  output  1  sticky; set when a pixel is requested and pix_valid is low; cleared at frame_start

Behaviour:
- Line length is L = 2*H_ACTIVE + H_BLANK clocks.
- h_cnt runs 0..L-1 and wraps. line_cnt counts lines within the current state.
- Reset: all outputs 0; state IDLE; counters 0; internal mode latch 0.
- States:
  - IDLE: outputs low, counters held at 0. When enable=1, go to VSYNC next cycle.
  - VSYNC (V_SYNC lines), then VBACK (V_BACK lines), then ACTIVE (V_ACTIVE lines), then VFRONT (V_FRONT lines).
  - At the last cycle of VFRONT: go to VSYNC if enable=1, else IDLE.
  - Each state lasts exactly its line count × L clocks.
  - Deasserting enable mid-frame never truncates the frame.
- Outputs are registered and lag the counters by one cycle.
- cmos_vsync = 1 for exactly V_SYNC×L consecutive cycles per frame. cmos_href = 0 outside ACTIVE.
- In ACTIVE, counter cycle h_cnt < 2*H_ACTIVE produces href=1 on the following cycle: 2*H_ACTIVE href-high cycles per line, then H_BLANK low.
- Request rule: pix_ready=1 on ACTIVE counter cycles with h_cnt even and < 2*H_ACTIVE, and only when the latched mode is upstream. pix_ready is 0 everywhere else, including in test-pattern mode.
- Handshake at a request cycle t:
  - If pix_valid=1: pixel P is consumed. cmos_data = P[15:8] at t+1 and P[7:0] at t+2.
  - If pix_valid=0: 16'h0000 is sent in place of the pixel and pix_underflow is set.
- Exactly H_ACTIVE×V_ACTIVE handshakes occur per frame; there is no back-pressure on the DVP side.
- cmos_data = 0 whenever href=0.
- Test pattern: pixel_x 0..H_ACTIVE-1, bar width W = H_ACTIVE/8, bar index = pixel_x / W.
  - Implement with a width counter and a bar counter, both reset at line start; no divider.
  - Colours, bars 0..7: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
- test_pattern is latched on the VSYNC entry cycle. Changes mid-frame take effect at the next frame.
- frame_start and pix_underflow clear on the same cycle: the clear wins, unless an underflow occurs in that cycle (impossible, since no requests happen in VSYNC).
- Asynchronous reset mid-frame: outputs drop to 0 immediately. After release the block restarts from IDLE; no partial frame resumes.

Test Plan (H_ACTIVE=8, H_BLANK=4, V_SYNC=1, V_BACK=1, V_ACTIVE=2, V_FRONT=1 → L=20, frame=100 clocks):
- Reset, then enable=1 held → frame_start pulses every 100 cycles; vsync high 20 cycles per frame; 2 href bursts of 16 cycles, 4 low cycles between; first href 40 cycles after vsync rises.
- Upstream mode, always valid, pixels 0x1234, 0x5678, … → bytes 12, 34, 56, 78, … in order; 8 handshakes per line, 16 per frame; pix_underflow stays 0.
- pix_valid dropped for the 3rd request of line 0 → bytes 00, 00 at href cycles 5–6; pix_underflow=1 until the next frame_start, then 0.
- test_pattern=1 → each line reads FF FF, FF E0, 07 FF, 07 E0, F8 1F, F8 00, 00 1F, 00 00; pix_ready never asserts.
- enable deasserted mid-ACTIVE → current frame completes all 100 cycles, then IDLE with all outputs 0; re-enable → frame_start on the next cycle's transition.
- sys_rstn pulsed low mid-line → vsync/href/data/pix_ready go 0 asynchronously; after release with enable=1, a full clean frame follows.
